mm_sched: RTL
=============

MM_SCHED -- requirements
Module: mm_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one modular multiplier.
REQ-002 Parameter MM_LAT, default 2, multiplier latency: cycles from operands sampled on mm_a/mm_b to r valid on mm_r.
REQ-003 Parameter W, default 256, operand and result width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester operation request.
REQ-007 req_a  input  NREQ*W  operand a; slice i belongs to requester i.
REQ-008 req_b  input  NREQ*W  operand b; slice i belongs to requester i.
REQ-009 req_ready  output  NREQ  one-hot or zero grant; handshake = req_valid[i] & req_ready[i].
REQ-010 rsp_valid  output  NREQ  one-hot or zero, one-cycle result strobe per requester.
REQ-011 rsp_r  output  W  result r = a*b mod p, shared by all requesters, qualified by rsp_valid.
REQ-012 mm_a, mm_b  output  W each  registered operands to the multiplier.
REQ-013 mm_vld  output  1  mm_a/mm_b carry a live operation this cycle.
REQ-014 mm_r  input  W  multiplier reduced result.
REQ-015 busy  output  1  any requester has an operation in flight.

Function
REQ-016 Each requester has a pending bit; requester i is eligible when req_valid[i]=1 and pending[i]=0.
REQ-017 Arbitration is round-robin: search starts at pointer ptr, lowest index at or after ptr (wrapping past NREQ-1 to 0) wins; at most one grant per cycle.
REQ-018 req_ready is combinational from req_valid, pending and ptr; no grant is given to an ineligible requester, including while rst=1.
REQ-019 On a handshake by requester g in cycle t: ptr <= (g+1) mod NREQ, pending[g] <= 1, mm_a/mm_b <= req_a/req_b slice g, mm_vld=1 in cycle t+1.
REQ-020 Cycles without a handshake leave ptr unchanged, drive mm_vld=0 the next cycle, and hold mm_a/mm_b.
REQ-021 A tag pipeline of depth MM_LAT carries {valid, requester id} alongside the multiplier; a bubble enters on idle cycles.
REQ-022 In cycle t+1+MM_LAT the tag exits, mm_r is registered into rsp_r, and rsp_valid[id] is asserted in cycle t+2+MM_LAT only; total latency is MM_LAT+2 cycles (4 at default).
REQ-023 pending[id] clears at the end of the rsp_valid cycle; requester id is eligible again from the following cycle.
REQ-024 Throughput: one issue per cycle across requesters; per requester one operation per MM_LAT+3 cycles.
REQ-025 Results return in issue order; no result backpressure; a requester must accept rsp_r in its rsp_valid cycle.
REQ-026 rsp_r holds its last value when rsp_valid is all-zero.
REQ-027 busy = OR of pending bits.
REQ-028 A req_valid deassertion without a handshake is legal; operands may change freely until handshake.

Reset
REQ-029 While rst=1: ptr=0, pending=0, tag pipeline valid bits=0, mm_vld=0, rsp_valid=0, mm_a=mm_b=0, rsp_r=0, busy=0.
REQ-030 Reset during an in-flight operation discards it: no rsp_valid is produced for it after rst deasserts.
REQ-031 First grant after reset is possible in the first cycle with rst=0.

Structure
REQ-032 Shared package holds NREQ, W and MM_LAT defaults and the requester-id width, clog2(NREQ).
REQ-033 One sub-module, rr_arb, is natural: NREQ-wide round-robin arbiter with eligible vector and ptr in, one-hot grant and encoded index out.
REQ-034 The multiplier is external; mm_sched contains no arithmetic beyond index and pointer logic.

Verification
REQ-035 Single request: req_valid[2]=1, a=3, b=5, model multiplier -> req_ready[2] cycle 0, mm_vld cycle 1, rsp_valid=4'b0100 with rsp_r=15 in cycle 4, busy high for cycles 1-4.
REQ-036 All four requesters held valid -> grants 0,1,2,3 on consecutive cycles; rsp_valid 0,1,2,3 in cycles 4-7; requester 0 regranted in cycle 5.
REQ-037 Fairness after a grant to requester 3 with ptr=0: requesters 1 and 3 valid -> grants alternate 1,3,1,3 with re-eligibility gaps honored.
REQ-038 Requester 1 keeps req_valid=1 after handshake -> no second req_ready[1] until the cycle after its rsp_valid.
REQ-039 Reset asserted in cycle 2 after a cycle-0 handshake -> no rsp_valid at any later cycle; busy=0 and ptr=0 after reset.
REQ-040 Idle gaps: handshakes in cycles 0 and 3 only -> mm_vld high in cycles 1 and 4 only; rsp_valid in cycles 4 and 7 only.

Source files
------------

// File: rtl/mm_sched_pkg.sv
// Shared defaults and helpers for the modular-multiplier scheduler.
package mm_sched_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int MM_LAT_DEF = 2;
    localparam int W_DEF      = 256;

    // Requester-id width; a single requester still needs one bit of id.
    function automatic int id_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    localparam int ID_W_DEF = id_width(NREQ_DEF);

endpackage

// File: rtl/mm_sched_if.sv
// Requester, response and multiplier bus of the scheduler.
interface mm_sched_if
    import mm_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_r;
    logic [W-1:0]      mm_a;
    logic [W-1:0]      mm_b;
    logic              mm_vld;
    logic [W-1:0]      mm_r;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, mm_r,
        output req_ready, rsp_valid, rsp_r, mm_a, mm_b, mm_vld, busy
    );

    modport master (
        output req_valid, req_a, req_b, mm_r,
        input  req_ready, rsp_valid, rsp_r, mm_a, mm_b, mm_vld, busy
    );
endinterface

// File: rtl/mm_sched_rr_arb.sv
// Round-robin arbiter: lowest eligible index at or after ptr wins.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    localparam logic [N-1:0] ONE_HOT0 = N'(1'b1);

    logic [N-1:0] rot_s;
    int           off_s;
    int           sum_s;

    // Rotate so ptr sits at bit 0, pick the first set bit, then undo the rotation.
    always_comb begin
        rot_s = N'({elig, elig} >> ptr);
        off_s = 0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                any   = 1'b1;
                off_s = k;
            end else begin
                off_s = off_s;
            end
        end
        sum_s = int'(ptr) + off_s;
        if (sum_s >= N) begin
            sum_s = sum_s - N;
        end else begin
            sum_s = sum_s;
        end
        idx = IW'(sum_s);
        if (any) begin
            gnt = ONE_HOT0 << idx;
        end else begin
            gnt = '0;
        end
    end
endmodule

// File: rtl/mm_sched.sv
// Shares one external pipelined modular multiplier among NREQ requesters.
module mm_sched
    import mm_sched_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int MM_LAT = MM_LAT_DEF,
    parameter int W      = W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    mm_sched_if.slave bus
);
    localparam int IW = id_width(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1'b1);

    logic [IW-1:0]             ptr_q, ptr_d;
    logic [NREQ-1:0]           pending_q, pending_d;
    logic [W-1:0]              mm_a_q, mm_a_d, mm_b_q, mm_b_d;
    logic                      mm_vld_q, mm_vld_d;
    logic [IW-1:0]             mm_id_q, mm_id_d;
    logic [MM_LAT-1:0]         tag_vld_q, tag_vld_d;
    logic [MM_LAT-1:0][IW-1:0] tag_id_q, tag_id_d;
    logic [NREQ-1:0]           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]              rsp_r_q, rsp_r_d;

    logic [NREQ-1:0]           elig_s, gnt_s;
    logic [IW-1:0]             gnt_idx_s;
    logic                      gnt_any_s, hs_s;

    assign elig_s = bus.req_valid & ~pending_q;

    rr_arb #(.N(NREQ), .IW(IW)) u_rr_arb (
        .elig (elig_s),
        .ptr  (ptr_q),
        .gnt  (gnt_s),
        .idx  (gnt_idx_s),
        .any  (gnt_any_s)
    );

    // Grants are withheld during reset so no requester sees a handshake that would be discarded.
    always_comb begin
        if (rst) begin
            bus.req_ready = '0;
            hs_s          = 1'b0;
        end else begin
            bus.req_ready = gnt_s;
            hs_s          = gnt_any_s;
        end
    end

    // Next state: issue on handshake, advance the tag pipe, retire the oldest tag.
    always_comb begin
        ptr_d       = ptr_q;
        pending_d   = pending_q & ~rsp_valid_q;
        mm_a_d      = mm_a_q;
        mm_b_d      = mm_b_q;
        mm_vld_d    = 1'b0;
        mm_id_d     = mm_id_q;
        tag_vld_d   = tag_vld_q;
        tag_id_d    = tag_id_q;
        rsp_valid_d = '0;
        rsp_r_d     = rsp_r_q;

        tag_vld_d[0] = mm_vld_q;
        tag_id_d[0]  = mm_id_q;
        for (int i = 1; i < MM_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        if (tag_vld_q[MM_LAT-1]) begin
            rsp_valid_d = ONE_HOT0 << tag_id_q[MM_LAT-1];
            rsp_r_d     = bus.mm_r;
        end else begin
            rsp_valid_d = '0;
        end

        if (hs_s) begin
            pending_d = pending_d | gnt_s;
            ptr_d     = (gnt_idx_s == IW'(NREQ - 1)) ? '0 : gnt_idx_s + 1'b1;
            mm_a_d    = bus.req_a[gnt_idx_s*W +: W];
            mm_b_d    = bus.req_b[gnt_idx_s*W +: W];
            mm_vld_d  = 1'b1;
            mm_id_d   = gnt_idx_s;
        end else begin
            mm_vld_d  = 1'b0;
        end
    end

    // State registers with synchronous reset; reset also drops any in-flight tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            pending_q   <= '0;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
            mm_vld_q    <= 1'b0;
            mm_id_q     <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_r_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            pending_q   <= pending_d;
            mm_a_q      <= mm_a_d;
            mm_b_q      <= mm_b_d;
            mm_vld_q    <= mm_vld_d;
            mm_id_q     <= mm_id_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
        end
    end

    assign bus.mm_a      = mm_a_q;
    assign bus.mm_b      = mm_b_q;
    assign bus.mm_vld    = mm_vld_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_r     = rsp_r_q;
    assign bus.busy      = |pending_q;
endmodule
